// File: rtl/msk_modulator_param.sv
// MSK (half-sine O-QPSK) modulator: pops chips from a FWFT FIFO, even chips shape I, odd chips shape Q.
// Flushes the pulses still in flight on FIFO underrun, then idles with both outputs at zero.
module msk_modulator_param #(
  parameter int DATA_W = 4,
  parameter int SPS    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_empty,
  input  logic                     i_data,
  output logic                     o_ready,
  output logic signed [DATA_W-1:0] o_sinI,
  output logic signed [DATA_W-1:0] o_sinQ,
  output logic                     o_busy
);

  localparam int PULSE_LEN = 2 * SPS;
  localparam int IDX_W     = $clog2(PULSE_LEN);
  localparam int PH_W      = $clog2(SPS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PULSE_LEN - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SPS - 1);

  function automatic logic signed [DATA_W-1:0] lut_entry(input int k);
    real amp;
    real s;
    amp = real'((1 << (DATA_W - 1)) - 1);
    s   = amp * $sin(3.14159265358979323846 * real'(k) / real'(PULSE_LEN));
    return DATA_W'($rtoi(s + 0.5));
  endfunction

  logic signed [DATA_W-1:0] lut [PULSE_LEN];

  for (genvar k = 0; k < PULSE_LEN; k++) begin : g_lut
    localparam logic signed [DATA_W-1:0] ENTRY = lut_entry(k);
    assign lut[k] = ENTRY;
  end

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t           state;
  logic [PH_W-1:0]  phase;
  logic             parity;
  logic             armed;
  logic             act_i;
  logic             act_q;
  logic             sign_i;
  logic             sign_q;
  logic [IDX_W-1:0] idx_i;
  logic [IDX_W-1:0] idx_q;
  logic             fetch_due;
  logic             pop_i;
  logic             pop_q;

  // armed keeps o_ready low for the first cycle after reset releases
  assign fetch_due = (state == IDLE) || ((state == RUN) && (phase == '0));
  assign o_ready   = fetch_due && !i_empty && !reset && armed;
  assign pop_i     = o_ready && !parity;
  assign pop_q     = o_ready && parity;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      phase  <= '0;
      parity <= 1'b0;
      armed  <= 1'b0;
      act_i  <= 1'b0;
      act_q  <= 1'b0;
      sign_i <= 1'b0;
      sign_q <= 1'b0;
      idx_i  <= '0;
      idx_q  <= '0;
      o_sinI <= '0;
      o_sinQ <= '0;
      o_busy <= 1'b0;
    end else begin
      armed  <= 1'b1;
      o_sinI <= act_i ? (sign_i ? lut[idx_i] : -lut[idx_i]) : '0;
      o_sinQ <= act_q ? (sign_q ? lut[idx_q] : -lut[idx_q]) : '0;

      // A reload on the final index restarts the pulse, so abutting pulses leave no gap
      if (pop_i) begin
        sign_i <= i_data;
        idx_i  <= '0;
        act_i  <= 1'b1;
      end else if (act_i) begin
        if (idx_i == IDX_LAST) act_i <= 1'b0;
        else                   idx_i <= idx_i + 1'b1;
      end

      if (pop_q) begin
        sign_q <= i_data;
        idx_q  <= '0;
        act_q  <= 1'b1;
      end else if (act_q) begin
        if (idx_q == IDX_LAST) act_q <= 1'b0;
        else                   idx_q <= idx_q + 1'b1;
      end

      if (o_ready) parity <= ~parity;

      case (state)
        IDLE: begin
          if (o_ready) begin
            state  <= RUN;
            phase  <= PH_W'(1);
            o_busy <= 1'b1;
          end else begin
            o_busy <= 1'b0;
          end
        end
        RUN: begin
          phase  <= (phase == PH_LAST) ? '0 : phase + 1'b1;
          o_busy <= 1'b1;
          if (fetch_due && i_empty) state <= FLUSH;
        end
        FLUSH: begin
          if (!act_i && !act_q) begin
            state  <= IDLE;
            parity <= 1'b0;
            phase  <= '0;
            o_busy <= 1'b0;
          end else begin
            o_busy <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msk_modulator_param.sv
// Directed scoreboard bench for msk_modulator_param: a 4-bit/8-SPS instance for the stream tests
// and a 6-bit/4-SPS instance for the alternate parametrisation.
module tb_msk_modulator_param;

  logic clk;
  logic reset;

  logic              i_empty_a, i_data_a, o_ready_a, o_busy_a;
  logic signed [3:0] o_sinI_a, o_sinQ_a;
  logic              i_empty_b, i_data_b, o_ready_b, o_busy_b;
  logic signed [5:0] o_sinI_b, o_sinQ_b;

  msk_modulator_param #(.DATA_W(4), .SPS(8)) dut_a (
    .clk(clk), .reset(reset), .i_empty(i_empty_a), .i_data(i_data_a),
    .o_ready(o_ready_a), .o_sinI(o_sinI_a), .o_sinQ(o_sinQ_a), .o_busy(o_busy_a)
  );

  msk_modulator_param #(.DATA_W(6), .SPS(4)) dut_b (
    .clk(clk), .reset(reset), .i_empty(i_empty_b), .i_data(i_data_b),
    .o_ready(o_ready_b), .o_sinI(o_sinI_b), .o_sinQ(o_sinQ_b), .o_busy(o_busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int rdy;
    int si;
    int sq;
    int busy;
  } exp_t;

  exp_t sb[$];
  bit   burst[$];
  bit   use_b;
  int   errors = 0;
  int   checks = 0;

  // Reference half-sine tables taken straight from the expected waveforms
  int lut_a[16] = '{0, 1, 3, 4, 5, 6, 6, 7, 7, 7, 6, 6, 5, 4, 3, 1};
  int lut_b[8]  = '{0, 12, 22, 29, 31, 29, 22, 12};

  function automatic int sps_now();
    return use_b ? 4 : 8;
  endfunction

  function automatic int lut_ref(input int m);
    return use_b ? lut_b[m] : lut_a[m];
  endfunction

  // Cycle c: c=0 is the cycle the first chip is presented; chip j pops at the end of cycle j*SPS
  function automatic exp_t model(input int c);
    exp_t e;
    int   n;
    int   sps;
    int   m;
    int   v;
    n      = burst.size();
    sps    = sps_now();
    e.rdy  = ((c % sps) == 0 && (c / sps) < n) ? 1 : 0;
    e.busy = (c >= 1 && c <= (n + 1) * sps + 1) ? 1 : 0;
    e.si   = 0;
    e.sq   = 0;
    for (int j = 0; j < n; j++) begin
      m = c - (j * sps + 2);
      if (m >= 0 && m < 2 * sps) begin
        v = burst[j] ? lut_ref(m) : -lut_ref(m);
        if ((j % 2) == 0) e.si = v;
        else              e.sq = v;
      end
    end
    return e;
  endfunction

  task automatic cmp(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s: observed empty scoreboard expected an entry", tag);
      return;
    end
    e = sb.pop_front();
    if (use_b) begin
      cmp({tag, "_rdy"},  int'(o_ready_b), e.rdy);
      cmp({tag, "_sinI"}, int'(o_sinI_b),  e.si);
      cmp({tag, "_sinQ"}, int'(o_sinQ_b),  e.sq);
      cmp({tag, "_busy"}, int'(o_busy_b),  e.busy);
    end else begin
      cmp({tag, "_rdy"},  int'(o_ready_a), e.rdy);
      cmp({tag, "_sinI"}, int'(o_sinI_a),  e.si);
      cmp({tag, "_sinQ"}, int'(o_sinQ_a),  e.sq);
      cmp({tag, "_busy"}, int'(o_busy_a),  e.busy);
    end
  endtask

  task automatic idleCycles(input int n, input string tag);
    exp_t z;
    z = '{rdy: 0, si: 0, sq: 0, busy: 0};
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      i_empty_a = 1'b1;
      i_empty_b = 1'b1;
      sb.push_back(z);
      #1 checkOutput($sformatf("%s_c%0d", tag, c));
    end
  endtask

  // Plays burst[] through a FWFT FIFO on the selected instance; rst_cyc>=0 asserts reset in that cycle and stops
  task automatic applyStimulus(input string tag, input int rst_cyc);
    int   n;
    int   sps;
    int   h;
    exp_t e;
    n   = burst.size();
    sps = sps_now();
    for (int c = 0; c < (n + 1) * sps + 4; c++) begin
      @(negedge clk);
      h = (c == 0) ? 0 : (c - 1) / sps + 1;
      if (use_b) begin
        i_empty_b = (h >= n);
        i_data_b  = (h < n) ? burst[h] : 1'b0;
      end else begin
        i_empty_a = (h >= n);
        i_data_a  = (h < n) ? burst[h] : 1'b0;
      end
      e = model(c);
      if (c == rst_cyc) begin
        reset = 1'b1;
        e.rdy = 0;
      end
      sb.push_back(e);
      #1 checkOutput($sformatf("%s_c%0d", tag, c));
      if (c == rst_cyc) break;
    end
  endtask

  initial begin
    exp_t z;
    bit   held;
    z         = '{rdy: 0, si: 0, sq: 0, busy: 0};
    use_b     = 1'b0;
    reset     = 1'b1;
    i_empty_a = 1'b1;
    i_data_a  = 1'b0;
    i_empty_b = 1'b1;
    i_data_b  = 1'b0;

    repeat (2) @(negedge clk);
    sb.push_back(z);
    #1 checkOutput("reset");
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] idle with empty FIFO");
    idleCycles(50, "idle");

    $display("[TB] single chip 1");
    burst = '{1'b1};
    applyStimulus("single", -1);

    $display("[TB] back-to-back chips 1,0,0,1");
    burst = '{1'b1, 1'b0, 1'b0, 1'b1};
    applyStimulus("stream", -1);

    $display("[TB] underrun after three chips, then restart");
    burst = '{1'b1, 1'b0, 1'b1};
    applyStimulus("under", -1);
    burst = '{1'b0};
    applyStimulus("restart", -1);

    $display("[TB] reset during a pop");
    burst = '{1'b1, 1'b0, 1'b0, 1'b1};
    applyStimulus("midrst", 16);
    held = burst[2];
    @(negedge clk);
    reset     = 1'b0;
    i_empty_a = 1'b0;
    i_data_a  = held;
    sb.push_back(z);
    #1 checkOutput("postrst");
    burst = '{1'b0, 1'b1};
    applyStimulus("resume", -1);

    $display("[TB] DATA_W=6 SPS=4 chip 0");
    use_b = 1'b1;
    burst = '{1'b0};
    applyStimulus("w6", -1);
    idleCycles(4, "w6idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
